// File: rtl/mult_unit.sv
`default_nettype none
// mult_unit: sequential shift-add signed multiplier for the EX stage; writes HI/LO.
// Rev 1.0

module mult_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [3:0]  MULT_CODE = 4'b1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_ctl,
  input  logic             ex_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH:0]       acc;
  logic [CW-1:0]        count;
  logic                 neg;

  logic                 accept;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;

  // Magnitude as unsigned WIDTH bits; the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  always_comb begin
    accept = (state == IDLE) && ex_valid && (alu_ctl == MULT_CODE) && !flush;
    sum    = acc + (mplier[0] ? {1'b0, mcand} : '0);
    prod   = {acc[WIDTH-1:0], mplier};
    stall  = accept || (state != IDLE);
    busy   = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= mag(op_a);
            mplier <= mag(op_b);
            neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            // Shift {acc, mplier} right by one, with the conditional add folded in.
            acc    <= {1'b0, sum[WIDTH:1]};
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            count  <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (!flush) begin
            {hi, lo} <= neg ? (~prod + (2*WIDTH)'(1)) : prod;
            done     <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_unit.sv
`default_nettype none
// tb_mult_unit: scenario tasks with randomized operands checked against a plain arithmetic product.
// Rev 1.0

module tb_mult_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   alu_ctl;
  logic         ex_valid;
  logic         flush;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  mult_unit #(.WIDTH(W), .MULT_CODE(4'b1000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_ctl  (alu_ctl),
    .ex_valid (ex_valid),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference: full 64-bit two's complement product of the sign-extended operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = $signed(a);
    eb = $signed(b);
    return 64'(ea * eb);
  endfunction

  // Present a mult in the cycle before the next edge; returns the combinational stall seen then.
  task automatic start_mult(input logic [31:0] a, input logic [31:0] b, output logic st);
    @(negedge clk);
    op_a = a; op_b = b; alu_ctl = 4'b1000; ex_valid = 1'b1;
    #1 st = stall;
    @(posedge clk);
    #1 alu_ctl = 4'b0011; ex_valid = 1'b0;
  endtask

  // Count edges after the accept until done is seen (-1 on timeout); tally stall-low cycles before it.
  task automatic wait_done(output int edges, output int stall_lo);
    edges = -1;
    stall_lo = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        edges = k;
        return;
      end
      if (!stall) stall_lo++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_ctl = 4'b0000; ex_valid = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({hi, lo, done, busy, stall} !== {64'd0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset: hi=%h lo=%h done=%b busy=%b stall=%b, want all zero", hi, lo, done, busy, stall);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic st; int e; int sl;
    start_mult(32'd7, 32'd6, st);
    wait_done(e, sl);
    vectors++;
    if (st !== 1'b1 || e != 33 || sl != 0) begin
      miscompares++;
      $display("FAIL basic_timing: stall_at_accept=%b done_edge=%0d stall_low=%0d, want 1/33/0", st, e, sl);
    end
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h2A || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: hi=%h lo=%h stall=%b, want 00000000 0000002a 0", hi, lo, stall);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pulse: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_flush();
    logic st; int seen;
    start_mult(32'd5, 32'd5, st);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || stall !== 1'b0 || hi !== 32'h0 || lo !== 32'd42) begin
      miscompares++;
      $display("FAIL flush_abort: busy=%b stall=%b hi=%h lo=%h, want 0 0 0 2a", busy, stall, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    vectors++;
    if (seen != 0 || lo !== 32'd42) begin
      miscompares++;
      $display("FAIL flush_no_done: done_pulses=%0d lo=%h, want 0 and 2a", seen, lo);
    end
    // A flush in IDLE must block the accept.
    @(negedge clk);
    op_a = 32'd9; op_b = 32'd9; alu_ctl = 4'b1000; ex_valid = 1'b1; flush = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_stall: stall=%b, want 0", stall);
    end
    @(posedge clk);
    #1 alu_ctl = 4'b0011; ex_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_busy: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_corners();
    logic [31:0] as [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] bs [4] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
    logic st; int e; int sl; logic [63:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = ref_prod(as[i], bs[i]);
      start_mult(as[i], bs[i], st);
      wait_done(e, sl);
      vectors++;
      if (e != 33 || {hi, lo} !== exp) begin
        miscompares++;
        $display("FAIL corner%0d: a=%h b=%h edge=%0d got=%h%h want=%h", i, as[i], bs[i], e, hi, lo, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic st; int e; int sl;
    start_mult(32'd3, 32'd3, st);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, want 0 0 0 0", hi, lo, busy, done);
    end
    start_mult(32'd3, 32'd3, st);
    wait_done(e, sl);
    vectors++;
    if (e != 33 || hi !== 32'h0 || lo !== 32'd9) begin
      miscompares++;
      $display("FAIL reset_rerun: edge=%0d hi=%h lo=%h, want 33 0 9", e, hi, lo);
    end
  endtask

  task automatic test_non_mult();
    logic [3:0] codes [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1111, 4'b0011};
    logic [31:0] h0; logic [31:0] l0;
    h0 = hi; l0 = lo;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      op_a = $urandom; op_b = $urandom;
      if (i < 8) begin
        alu_ctl = codes[i]; ex_valid = 1'b1;
      end else begin
        alu_ctl = 4'b1000; ex_valid = 1'b0;
      end
      #1;
      vectors++;
      if (stall !== 1'b0) begin
        miscompares++;
        $display("FAIL non_mult_stall: alu_ctl=%b ex_valid=%b stall=%b, want 0", alu_ctl, ex_valid, stall);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || hi !== h0 || lo !== l0) begin
        miscompares++;
        $display("FAIL non_mult_state: busy=%b hi=%h lo=%h, want 0 %h %h", busy, hi, lo, h0, l0);
      end
    end
    alu_ctl = 4'b0011; ex_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic st; int e; int sl; logic [63:0] first;
    first = ref_prod(32'h0000_1234, 32'hFFFF_FFF0);
    start_mult(32'h0000_1234, 32'hFFFF_FFF0, st);
    wait_done(e, sl);
    vectors++;
    if (e != 33 || {hi, lo} !== first) begin
      miscompares++;
      $display("FAIL b2b_first: edge=%0d got=%h%h want=%h", e, hi, lo, first);
    end
    // Still inside the done cycle: issue the next mult with no gap.
    op_a = 32'd2; op_b = 32'd3; alu_ctl = 4'b1000; ex_valid = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept_stall: stall=%b, want 1", stall);
    end
    @(posedge clk);
    #1 alu_ctl = 4'b0011; ex_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || {hi, lo} !== first) begin
      miscompares++;
      $display("FAIL b2b_hold: busy=%b got=%h%h want busy 1 and %h", busy, hi, lo, first);
    end
    wait_done(e, sl);
    vectors++;
    if (e != 33 || hi !== 32'h0 || lo !== 32'd6) begin
      miscompares++;
      $display("FAIL b2b_second: edge=%0d hi=%h lo=%h, want 33 0 6", e, hi, lo);
    end
  endtask

  task automatic test_random();
    logic st; int e; int sl; logic [31:0] a; logic [31:0] b; logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: b = 32'h8000_0000;
        2: b = $urandom_range(0, 15);
        3: a = -($urandom_range(1, 300));
        default: ;
      endcase
      exp = ref_prod(a, b);
      start_mult(a, b, st);
      wait_done(e, sl);
      vectors++;
      if (st !== 1'b1 || e != 33 || sl != 0 || {hi, lo} !== exp) begin
        miscompares++;
        $display("FAIL random%0d: a=%h b=%h st=%b edge=%0d stall_low=%0d got=%h%h want=%h",
                 i, a, b, st, e, sl, hi, lo, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_corners();
    test_reset_mid();
    test_non_mult();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
